dcache_readback_packer: RTL and testbench
=========================================

DCACHE_READBACK_PACKER -- requirements
Module: dcache_readback_packer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 28'h1000000, DDR line address of the first line read.
REQ-002 SHALL have parameter ADDR_STRIDE, default 8, address increment per line.
REQ-003 SHALL have parameter NUM_LINES, default 19200, lines read per run (1..32767).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port start  in  1  one-cycle run request.
REQ-008 SHALL have port busy  out  1  run in progress.
REQ-009 SHALL have port done  out  1  run complete and FIFO drained; held until next accepted start.
REQ-010 SHALL have port fmt_err  out  1  sticky: a read word had nonzero bits [31:8].
REQ-011 SHALL have port mem_data_addr1  out  28  DDR read address.
REQ-012 SHALL have port mem_rw_data1  out  1  tied 0 (read only).
REQ-013 SHALL have port mem_valid_data1  out  1  request valid.
REQ-014 SHALL have port mem_ready_data1  in  1  response ready; mem_data_rd1 valid this cycle.
REQ-015 SHALL have port mem_data_rd1  in  256  read line.
REQ-016 SHALL have port mem_data_wr1  out  256  tied 0.
REQ-017 SHALL have port out_data  out  64  packed bytes, FIFO head.
REQ-018 SHALL have port out_valid  out  1  FIFO not empty.
REQ-019 SHALL have port out_ready  in  1  consumer accepts; pop when out_valid & out_ready.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, DRAIN, FINISHED.
REQ-021 IDLE: start=1 -> ISSUE; line counter cleared; address loaded with BASE_ADDR; fmt_err cleared; done cleared.
REQ-022 ISSUE: if FIFO count < FIFO_DEPTH -> assert mem_valid_data1 next cycle, go to WAIT_RSP; otherwise stay in ISSUE with mem_valid_data1=0.
REQ-023 WAIT_RSP: mem_valid_data1 and mem_data_addr1 held stable until mem_ready_data1=1.
REQ-024 On mem_ready_data1=1 in WAIT_RSP: capture line, push packed word, deassert mem_valid_data1 next cycle, add ADDR_STRIDE to address (28-bit wrap), increment line counter.
REQ-025 After capture: line counter == NUM_LINES -> DRAIN; else -> ISSUE. At least one cycle with mem_valid_data1=0 between requests.
REQ-026 mem_ready_data1 outside WAIT_RSP SHALL be ignored; no push occurs.
REQ-027 Packing: out_data[8k+7:8k] = mem_data_rd1[32k+7:32k], k=0..7.
REQ-028 fmt_err SHALL set on capture if any mem_data_rd1[32k+31:32k+8] != 0; it is held until the next accepted start.
REQ-029 FIFO: first-word-fall-through; push and pop in the same cycle leaves the count unchanged. When full, out_valid=1 and no push is issued (REQ-022). Pop when empty has no effect.
REQ-030 DRAIN: FIFO empty -> FINISHED. FINISHED: done=1; start=1 -> behaves as IDLE start (REQ-021).
REQ-031 busy=1 in ISSUE, WAIT_RSP, DRAIN; start while busy SHALL be ignored.
REQ-032 Latency: start at cycle N -> mem_valid_data1=1 at N+2 (empty FIFO); ready at cycle M -> out_valid=1 at M+1.

Reset
REQ-033 rst=0 SHALL asynchronously force: IDLE, mem_valid_data1=0, mem_data_addr1=BASE_ADDR, busy=0, done=0, fmt_err=0, FIFO empty, out_valid=0, out_data=0, line counter 0.
REQ-034 Reset mid-transfer SHALL abandon the outstanding request; mem_valid_data1 drops immediately and no FIFO data survives.

Verification
REQ-035 NUM_LINES=3, ready always 1 after 2 cycles, out_ready=1 -> addresses 0x1000000, 0x1000008, 0x1000010; 3 words out; done=1; fmt_err=0.
REQ-036 Line with word k = 0x000000(10+k) -> out_data = 64'h1716151413121110.
REQ-037 out_ready=0, NUM_LINES=8, FIFO_DEPTH=4 -> exactly 4 requests, ISSUE stalls with mem_valid_data1=0; raising out_ready completes 8 words in order.
REQ-038 Word 3 = 32'h00000155 -> fmt_err=1, out byte 3 = 8'h55; fmt_err stays 1 until next start.
REQ-039 rst=0 while mem_valid_data1=1 -> next sample shows mem_valid_data1=0, out_valid=0, busy=0; a subsequent start restarts at 0x1000000.
REQ-040 start pulse during busy, plus mem_ready_data1 pulse during DRAIN -> no extra request issued, no extra word output, line count unchanged.

Source files
------------

// File: rtl/dcache_readback_packer.sv
// Streams NUM_LINES 256-bit DDR lines, keeps the low byte of each 32-bit word,
// and queues the resulting 64-bit words in a small first-word-fall-through FIFO.
module dcache_readback_packer #(
   parameter logic [27:0] BASE_ADDR   = 28'h1000000,
   parameter int unsigned ADDR_STRIDE = 8,
   parameter int unsigned NUM_LINES   = 19200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         fmt_err,
   output logic [27:0]  mem_data_addr1,
   output logic         mem_rw_data1,
   output logic         mem_valid_data1,
   input  logic         mem_ready_data1,
   input  logic [255:0] mem_data_rd1,
   output logic [255:0] mem_data_wr1,
   output logic [63:0]  out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, DRAIN, FINISHED} state_t;
   state_t state, state_nx;

   logic [15:0]   line_cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [63:0]   fifo_mem [FIFO_DEPTH];
   logic [63:0]   packed_word;
   logic          bad_word, start_acc, capture, last_line, pop, fifo_full, fifo_empty;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign start_acc  = start && ((state == IDLE) || (state == FINISHED));
   assign capture    = (state == WAIT_RSP) && mem_ready_data1;
   assign last_line  = ((line_cnt + 16'd1) == 16'(NUM_LINES));
   assign pop        = out_valid && out_ready;

   assign mem_rw_data1 = 1'b0;
   assign mem_data_wr1 = '0;
   assign out_valid    = !fifo_empty;
   assign out_data     = fifo_empty ? '0 : fifo_mem[rd_ptr];

   always_comb begin
      packed_word = '0;
      bad_word    = 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
         packed_word[8*k +: 8] = mem_data_rd1[32*k +: 8];
         bad_word = bad_word | (|mem_data_rd1[32*k+8 +: 24]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, FINISHED: if (start) state_nx = ISSUE;
         ISSUE:          if (!fifo_full) state_nx = WAIT_RSP;
         WAIT_RSP:       if (mem_ready_data1) state_nx = last_line ? DRAIN : ISSUE;
         DRAIN:          if (fifo_empty) state_nx = FINISHED;
         default:        state_nx = IDLE;
      endcase
   end

   // The request strobe is a pure decode of WAIT_RSP, so a reset drops it at once.
   always_comb begin
      busy            = (state == ISSUE) || (state == WAIT_RSP) || (state == DRAIN);
      done            = (state == FINISHED);
      mem_valid_data1 = (state == WAIT_RSP);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_data_addr1 <= BASE_ADDR;
         line_cnt       <= '0;
         fmt_err        <= 1'b0;
      end else if (start_acc) begin
         mem_data_addr1 <= BASE_ADDR;
         line_cnt       <= '0;
         fmt_err        <= 1'b0;
      end else if (capture) begin
         mem_data_addr1 <= mem_data_addr1 + 28'(ADDR_STRIDE);
         line_cnt       <= line_cnt + 16'd1;
         if (bad_word) fmt_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (capture) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({capture, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (capture) fifo_mem[wr_ptr] <= packed_word;
   end
endmodule

// File: tb/tb_dcache_readback_packer.sv
// Randomized bench: a DDR responder feeds lines and records expected packed words,
// an independent monitor checks every word the packer hands out.
module tb_dcache_readback_packer;
   localparam logic [27:0] BASE   = 28'h1000000;
   localparam int unsigned STRIDE = 8;
   localparam int unsigned NL     = 8;
   localparam int unsigned FD     = 4;

   logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic         busy, done, fmt_err, mem_rw, mem_valid, mem_ready;
   logic [27:0]  mem_addr;
   logic [255:0] mem_rd, mem_wr;
   logic [63:0]  out_data;
   logic         out_valid, out_ready;

   int checks = 0, errors = 0;
   logic [63:0]  exp_q[$];
   logic [255:0] line_q[$];
   int n_caps = 0, resp_limit = 1000000, ordy_mode = 1;
   bit allow_bad = 1'b0, exp_fmt = 1'b0, stray_req = 1'b0;

   always #5 clk = ~clk;

   dcache_readback_packer #(
      .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE), .NUM_LINES(NL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fmt_err(fmt_err),
      .mem_data_addr1(mem_addr), .mem_rw_data1(mem_rw), .mem_valid_data1(mem_valid),
      .mem_ready_data1(mem_ready), .mem_data_rd1(mem_rd), .mem_data_wr1(mem_wr),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected packed word: low byte of each 32-bit word, by arithmetic.
   function automatic logic [63:0] pack(input logic [255:0] l);
      logic [63:0] r;
      logic [31:0] w;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         w = l[32*k +: 32];
         r = r | (64'(w % 256) << (8*k));
      end
      return r;
   endfunction

   function automatic bit is_bad(input logic [255:0] l);
      logic [31:0] w;
      bit b;
      b = 1'b0;
      for (int k = 0; k < 8; k++) begin
         w = l[32*k +: 32];
         if (w > 255) b = 1'b1;
      end
      return b;
   endfunction

   function automatic logic [255:0] make_line();
      logic [255:0] l;
      logic [31:0]  w;
      l = '0;
      for (int k = 0; k < 8; k++) begin
         w = 32'($urandom_range(0, 255));
         if (allow_bad && ($urandom_range(0, 15) == 0))
            w = w | (32'($urandom_range(1, 24'hFFFFFF)) << 8);
         l[32*k +: 32] = w;
      end
      return l;
   endfunction

   initial begin : responder
      logic [255:0] l;
      logic [27:0]  a;
      int dly;
      mem_ready = 1'b0;
      mem_rd    = '0;
      forever begin
         @(negedge clk);
         if (stray_req && !mem_valid) begin
            @(posedge clk); #1; mem_ready = 1'b1; mem_rd = {8{32'hDEAD00AA}};
            @(posedge clk); #1; mem_ready = 1'b0; mem_rd = '0; stray_req = 1'b0;
         end else if (rst && mem_valid && (n_caps < resp_limit)) begin
            a = BASE + 28'(n_caps * STRIDE);
            chk("req_addr", mem_addr, a);
            dly = $urandom_range(0, 3);
            repeat (dly) begin
               @(negedge clk);
               chk("req_hold", {mem_valid, mem_addr}, {1'b1, a});
            end
            l = (line_q.size() != 0) ? line_q.pop_front() : make_line();
            @(posedge clk); #1; mem_ready = 1'b1; mem_rd = l;
            @(negedge clk);
            exp_q.push_back(pack(l));
            if (is_bad(l)) exp_fmt = 1'b1;
            n_caps++;
            @(posedge clk); #1; mem_ready = 1'b0; mem_rd = {8{$urandom}};
            @(negedge clk);
            chk("req_gap", mem_valid, 1'b0);
            chk("out_latency", out_valid, 1'b1);
         end
      end
   end

   initial begin : consumer
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ordy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %0h expected no word", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", out_data, e);
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic start_run();
      n_caps  = 0;
      exp_fmt = 1'b0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("done_cleared", done, 1'b0);
      chk("fmt_cleared", fmt_err, 1'b0);
      chk("valid_at_n1", mem_valid, 1'b0);
      @(posedge clk); #1;
      chk("valid_at_n2", mem_valid, 1'b1);
      chk("first_addr", mem_addr, BASE);
   endtask

   task automatic wait_caps(input int n);
      int t;
      t = 0;
      while ((n_caps < n) && (t < 2000)) begin @(posedge clk); #1; t++; end
      chk("caps_reached", (n_caps >= n), 1'b1);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!done && (t < 5000)) begin @(posedge clk); #1; t++; end
      chk("done", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      chk("lines_read", n_caps, NL);
      chk("fmt_err", fmt_err, exp_fmt);
      chk("words_pending", exp_q.size(), 0);
      chk("out_valid_at_done", out_valid, 1'b0);
   endtask

   initial begin : main
      logic [255:0] l;
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_fmt", fmt_err, 1'b0);
      chk("rst_valid", mem_valid, 1'b0);
      chk("rst_addr", mem_addr, BASE);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rw_tied", mem_rw, 1'b0);
      chk("wr_tied", mem_wr, 256'h0);
      rst = 1'b1;

      // Directed line 0x10..0x17 first, then clean random lines, free-running consumer.
      l = '0;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h10 + 32'(k);
      line_q.push_back(l);
      ordy_mode = 1;
      start_run();
      wait_done();

      // Word 3 carries stray upper bits; fmt_err must stick after the run.
      l = make_line();
      l[32*3 +: 32] = 32'h00000155;
      line_q.push_back(l);
      ordy_mode = 2;
      start_run();
      wait_done();
      repeat (10) @(posedge clk);
      #1;
      chk("fmt_sticky", fmt_err, 1'b1);
      chk("done_held", done, 1'b1);

      // Consumer stalled: only FD requests may go out before the FIFO fills.
      ordy_mode = 0;
      start_run();
      repeat (60) @(posedge clk);
      #1;
      chk("stall_caps", n_caps, FD);
      chk("stall_valid", mem_valid, 1'b0);
      chk("stall_busy", busy, 1'b1);
      chk("stall_out_valid", out_valid, 1'b1);
      ordy_mode = 1;
      wait_done();

      // Start while busy, then a stray ready while draining.
      allow_bad = 1'b1;
      ordy_mode = 1;
      start_run();
      wait_caps(3);
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      wait_caps(NL - 1);
      ordy_mode = 0;
      wait_caps(NL);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_busy", busy, 1'b1);
      chk("drain_done", done, 1'b0);
      chk("drain_out_valid", out_valid, 1'b1);
      stray_req = 1'b1;
      t = 0;
      while (stray_req && (t < 50)) begin @(posedge clk); #1; t++; end
      chk("stray_issued", stray_req, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("stray_caps", n_caps, NL);
      chk("stray_valid", mem_valid, 1'b0);
      chk("stray_fmt", fmt_err, exp_fmt);
      ordy_mode = 1;
      wait_done();

      // Reset while a request is outstanding and the FIFO holds data.
      resp_limit = 2;
      ordy_mode  = 0;
      start_run();
      wait_caps(2);
      t = 0;
      while (!mem_valid && (t < 50)) begin @(posedge clk); #1; t++; end
      chk("pre_rst_valid", mem_valid, 1'b1);
      chk("pre_rst_out_valid", out_valid, 1'b1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", mem_valid, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_addr", mem_addr, BASE);
      chk("mid_rst_out_data", out_data, 64'h0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      resp_limit = 1000000;
      ordy_mode  = 2;
      start_run();
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
